branch_condition_unit: RTL and testbench
========================================

Name: branch_condition_unit

Overview:
- Consumer side of the processor status flags: samples the registered C,Z,L,F,N vector and resolves conditional branches and jumps (Bcond/Jcond, 4-bit condition codes).
- Sits between decode and fetch. Accepts one branch request at a time over a valid/ready handshake.
- On a taken branch, issues a one-cycle PC redirect, then holds a flush for a fixed number of cycles.
- Waits while a flag update is still in flight.

Parameters:
- ADDR_WIDTH, 16, width of PC, target register and redirect address.
- DISP_WIDTH, 8, width of the signed branch displacement.
- FLUSH_CYCLES, 2, cycles flush stays high after a taken redirect (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- br_valid  in  1  decode presents a branch/jump request.
- br_ready  out  1  unit can accept a request (high only in IDLE).
- br_cond  in  4  condition code.
- br_is_jump  in  1  1 = jump to br_target; 0 = PC-relative branch.
- br_pc  in  ADDR_WIDTH  PC of the branch instruction.
- br_disp  in  DISP_WIDTH  signed displacement.
- br_target  in  ADDR_WIDTH  register jump target.
- flags_in  in  5  status flags, bit order [4]=C [3]=Z [2]=L [1]=F [0]=N.
- flags_pending  in  1  an in-flight instruction will update flags_in.
- resolve_valid  out  1  one-cycle pulse: the request has been resolved.
- taken  out  1  resolution result, valid with resolve_valid.
- redirect_valid  out  1  one-cycle pulse, fetch loads redirect_pc.
- redirect_pc  out  ADDR_WIDTH  new fetch address.
- flush  out  1  squash younger instructions.

Behaviour:
- Reset, effective immediately and asynchronously:
  - state=IDLE, br_ready=1.
  - resolve_valid, taken, redirect_valid, flush = 0; redirect_pc = 0.
  - flush counter = 0; latched request fields = 0.
- FSM states: IDLE, WAIT_FLAGS, EVAL, FLUSH.
- IDLE: on br_valid & br_ready, latch br_cond, br_is_jump, br_pc, br_disp, br_target.
  - flags_pending=1 in the accept cycle -> WAIT_FLAGS; else -> EVAL.
- WAIT_FLAGS: remain while flags_pending=1. First cycle with flags_pending=0 -> EVAL.
- EVAL: sample flags_in combinationally this cycle and compute cond_true.
  - Outputs are registered and appear the cycle after EVAL.
  - Minimum accept-to-resolve_valid latency is 2 cycles.
  - Not taken: resolve_valid=1, taken=0 -> IDLE.
  - Taken: resolve_valid=1, taken=1, redirect_valid=1, redirect_pc loaded, flush=1, counter=FLUSH_CYCLES-1 -> FLUSH.
- FLUSH: flush=1. Counter decrements each cycle; at 0, flush drops and state -> IDLE. br_ready stays low.
- Target address:
  - Branch: br_pc + sign_extend(br_disp), modulo 2^ADDR_WIDTH (wrap-around, no error).
  - Jump: br_target unchanged.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 HI L; 5 LS !L; 6 GT N; 7 LE !N.
  - 8 FS F; 9 FC !F; 10 LO !L&!Z; 11 HS L|Z.
  - 12 LT !N&!Z; 13 GE N|Z; 14 UC 1; 15 NV 0.
- Held outputs: redirect_pc holds its last value until the next taken resolution. taken holds until the next resolve_valid.
- br_valid while br_ready=0 is ignored; the request is not latched.
- Reset asserted mid-WAIT/EVAL/FLUSH: request is discarded, no resolve/redirect pulse, flush drops immediately.

Decomposition:
- Shared package holds:
  - condition-code constants COND_EQ..COND_NV;
  - flag bit indices FLAG_C=4, FLAG_Z=3, FLAG_L=2, FLAG_F=1, FLAG_N=0;
  - FSM state encoding.
- One combinational sub-module, cond_eval (cond[3:0], flags[4:0] -> cond_true), reused by the decode-stage predictor.

Test Plan:
- Reset asserted mid-FLUSH: flush, redirect_valid -> 0 immediately; after release, br_ready=1 and redirect_pc=0.
- EQ branch, flags_in=5'b01000, br_pc=0x0100, br_disp=0xFC, flags_pending=0:
  - resolve_valid, taken=1, redirect_valid=1, redirect_pc=0x00FC exactly 2 cycles after accept;
  - flush high 2 cycles, br_ready returns the cycle after.
- NE branch with flags_in=5'b01000 -> resolve_valid=1, taken=0, redirect_valid=0, flush=0, br_ready=1 next cycle.
- Jump UC, br_target=0xBEEF, flags_pending high 3 cycles after accept:
  - resolve_valid appears 2 cycles after flags_pending falls;
  - redirect_pc=0xBEEF.
- Wrap-around: br_pc=0xFFFE, br_disp=0x04, GE with flags N=1 -> redirect_pc=0x0002.
- Sweep all 16 conditions x all 32 flag vectors against the reference table; also pulse br_valid during FLUSH -> ignored (no second resolve_valid).

Source files
------------

// File: rtl/branch_condition_unit_pkg.sv
// branch_condition_unit_pkg: condition codes, flag bit positions and FSM encoding for branch resolution
package branch_condition_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int FLAG_C = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_L = 2;
  localparam int FLAG_F = 1;
  localparam int FLAG_N = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FLAGS, ST_EVAL, ST_FLUSH} state_t;
endpackage

// File: rtl/branch_condition_unit_cond_eval.sv
// cond_eval: resolves a 4-bit condition code against the C,Z,L,F,N flag vector
module cond_eval
  import branch_condition_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       cond_true
);
  logic c, z, l, f, n, base;
  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];
  assign n = flags[FLAG_N];
  // every odd code is the complement of the even code below it
  always_comb begin
    base = 1'b0;
    case ({cond[3:1], 1'b0})
      COND_EQ: base = z;
      COND_CS: base = c;
      COND_HI: base = l;
      COND_GT: base = n;
      COND_FS: base = f;
      COND_LO: base = !l && !z;
      COND_LT: base = !n && !z;
      COND_UC: base = 1'b1;
      default: base = 1'b0;
    endcase
  end
  assign cond_true = base ^ cond[0];
endmodule

// File: rtl/branch_condition_unit.sv
// branch_condition_unit: resolves Bcond/Jcond requests from status flags and drives fetch redirect/flush
module branch_condition_unit
  import branch_condition_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DISP_WIDTH   = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [3:0]            br_cond,
  input  logic                  br_is_jump,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic [DISP_WIDTH-1:0] br_disp,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic [4:0]            flags_in,
  input  logic                  flags_pending,
  output logic                  resolve_valid,
  output logic                  taken,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush
);
  state_t state, state_n;
  logic [3:0] cnt, cond_q;
  logic jump_q, cond_true;
  logic [ADDR_WIDTH-1:0] pc_q, target_q, dest;
  logic [DISP_WIDTH-1:0] disp_q;
  cond_eval u_cond_eval (.cond(cond_q), .flags(flags_in), .cond_true(cond_true));
  assign dest = jump_q ? target_q : pc_q + ADDR_WIDTH'($signed(disp_q));
  assign br_ready = state == ST_IDLE;
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:       state_n = br_valid ? (flags_pending ? ST_WAIT_FLAGS : ST_EVAL) : ST_IDLE;
      ST_WAIT_FLAGS: state_n = flags_pending ? ST_WAIT_FLAGS : ST_EVAL;
      ST_EVAL:       state_n = cond_true ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:      state_n = cnt == 4'd0 ? ST_IDLE : ST_FLUSH;
      default:       state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cond_q         <= '0;
      jump_q         <= 1'b0;
      pc_q           <= '0;
      disp_q         <= '0;
      target_q       <= '0;
      resolve_valid  <= 1'b0;
      taken          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      state          <= state_n;
      resolve_valid  <= 1'b0;
      redirect_valid <= 1'b0;
      if (state == ST_IDLE && br_valid) begin
        cond_q   <= br_cond;
        jump_q   <= br_is_jump;
        pc_q     <= br_pc;
        disp_q   <= br_disp;
        target_q <= br_target;
      end
      if (state == ST_EVAL) begin
        resolve_valid  <= 1'b1;
        taken          <= cond_true;
        redirect_valid <= cond_true;
        flush          <= cond_true;
        if (cond_true) begin
          redirect_pc <= dest;
          cnt         <= 4'(FLUSH_CYCLES - 1);
        end
      end
      if (state == ST_FLUSH) begin
        flush <= cnt != 4'd0;
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_condition_unit.sv
// tb_branch_condition_unit: directed and randomized checks of branch resolution against a flag-rule model
module tb_branch_condition_unit;
  localparam int FC = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic br_valid = 1'b0, br_ready, br_is_jump = 1'b0, flags_pending = 1'b0;
  logic [3:0] br_cond = '0;
  logic [15:0] br_pc = '0, br_target = '0, redirect_pc;
  logic [7:0] br_disp = '0;
  logic [4:0] flags_in = '0;
  logic resolve_valid, taken, redirect_valid, flush;
  int n_cmp = 0, n_err = 0;
  logic [15:0] exp_rpc = '0;

  branch_condition_unit #(.ADDR_WIDTH(16), .DISP_WIDTH(8), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_is_jump(br_is_jump), .br_pc(br_pc), .br_disp(br_disp),
    .br_target(br_target), .flags_in(flags_in), .flags_pending(flags_pending),
    .resolve_valid(resolve_valid), .taken(taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [3:0] c, input logic [4:0] f);
    bit fc, fz, fl, ff, fn;
    {fc, fz, fl, ff, fn} = f;
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fl;
      4'd5:  return !fl;
      4'd6:  return fn;
      4'd7:  return !fn;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !fl && !fz;
      4'd11: return fl || fz;
      4'd12: return !fn && !fz;
      4'd13: return fn || fz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ref_dest(input logic j, input logic [15:0] pc, input logic [7:0] d, input logic [15:0] tg);
    int s;
    s = d >= 8'd128 ? int'(d) - 256 : int'(d);
    return j ? tg : 16'((int'(pc) + s + 65536) % 65536);
  endfunction

  // pend > 0: flags_pending held for the accept cycle plus pend more cycles
  task automatic do_req(input logic [3:0] c, input logic j, input logic [15:0] pc, input logic [7:0] d,
                        input logic [15:0] tg, input logic [4:0] f, input int pend, input bit poke);
    bit t;
    int lat;
    t = ref_cond(c, f);
    lat = pend > 0 ? pend + 3 : 2;
    @(negedge clock);
    check("ready_idle", br_ready, 1);
    br_valid = 1'b1; br_cond = c; br_is_jump = j; br_pc = pc; br_disp = d; br_target = tg;
    flags_pending = pend > 0;
    flags_in = pend > 0 ? 5'($urandom) : f;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      if (k == 1) begin
        br_valid = 1'b0; br_cond = 4'($urandom); br_is_jump = 1'($urandom);
        br_pc = 16'($urandom); br_disp = 8'($urandom); br_target = 16'($urandom);
      end
      if (k == pend + 1) begin flags_pending = 1'b0; flags_in = f; end
      if (k < lat) check("no_early_resolve", resolve_valid, 0);
    end
    if (t) exp_rpc = ref_dest(j, pc, d, tg);
    check("resolve_valid", resolve_valid, 1);
    check("taken", taken, t);
    check("redirect_valid", redirect_valid, t);
    check("redirect_pc", redirect_pc, exp_rpc);
    check("flush_first", flush, t);
    check("ready_at_resolve", br_ready, !t);
    if (t) begin
      if (poke) begin br_valid = 1'b1; br_cond = 4'd14; end
      for (int k = 1; k < FC; k++) begin
        @(negedge clock);
        check("flush_hold", flush, 1);
        check("ready_low_flush", br_ready, 0);
        check("no_pulse_flush", {resolve_valid, redirect_valid}, 0);
      end
      @(negedge clock);
      br_valid = 1'b0;
      check("flush_drop", flush, 0);
      check("ready_after_flush", br_ready, 1);
      check("no_resolve_after_flush", resolve_valid, 0);
    end
  endtask

  initial begin
    #1;
    check("rst_ready", br_ready, 1);
    check("rst_outs", {resolve_valid, taken, redirect_valid, flush}, 0);
    check("rst_rpc", redirect_pc, 0);
    @(negedge clock);
    reset = 1'b0;
    // reset during flush discards the request
    @(negedge clock);
    br_valid = 1'b1; br_cond = 4'd14; br_is_jump = 1'b1; br_target = 16'h1234; flags_pending = 1'b0;
    @(negedge clock);
    br_valid = 1'b0;
    @(negedge clock);
    check("pre_rst_flush", flush, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_flush", flush, 0);
    check("rst_mid_redirect", redirect_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", br_ready, 1);
    check("post_rst_rpc", redirect_pc, 0);
    check("post_rst_flush", flush, 0);
    exp_rpc = '0;
    do_req(4'd0, 1'b0, 16'h0100, 8'hFC, 16'h0000, 5'b01000, 0, 1'b0);
    check("eq_rpc_value", redirect_pc, 16'h00FC);
    do_req(4'd1, 1'b0, 16'h2000, 8'h10, 16'h0000, 5'b01000, 0, 1'b0);
    do_req(4'd14, 1'b1, 16'h3000, 8'h00, 16'hBEEF, 5'b00000, 3, 1'b1);
    check("jump_rpc_value", redirect_pc, 16'hBEEF);
    do_req(4'd13, 1'b0, 16'hFFFE, 8'h04, 16'h0000, 5'b00001, 0, 1'b0);
    check("wrap_rpc_value", redirect_pc, 16'h0002);
    for (int c = 0; c < 16; c++)
      for (int fv = 0; fv < 32; fv++)
        do_req(4'(c), 1'($urandom), 16'($urandom), 8'($urandom), 16'($urandom), 5'(fv),
               int'($urandom_range(0, 2)), fv[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
